// File: rtl/regfile_writeback.sv
// Merges single-cycle ALU results and queued load results onto the one register-file write port.
// Optional starvation guard: WB_STARVE_GUARD_EN. Latency: 1 cycle ALU grant to writeEn; loads take 2 or more cycles. Backpressure: mem_ready drops when the queue is full.
module regfile_writeback #(
    parameter int DEPTH        = 4,
    parameter int AW           = 6,
    parameter int DW           = 64,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    input  logic [AW-1:0]            alu_rd,
    input  logic [DW-1:0]            alu_data,
    output logic                     alu_stall,
    input  logic                     mem_valid,
    input  logic [AW-1:0]            mem_rd,
    input  logic [DW-1:0]            mem_data,
    output logic                     mem_ready,
    input  logic [AW-1:0]            query_rd,
    output logic                     pending,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [AW-1:0]            addressw,
    output logic [DW-1:0]            writeData,
    output logic                     writeEn
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_bad_params
        $error("regfile_writeback: DEPTH must be a power of two >= 2 and STARVE_LIMIT >= 1");
    end

    logic [AW-1:0]    r_ent_rd   [DEPTH];
    logic [DW-1:0]    r_ent_data [DEPTH];
    logic [DEPTH-1:0] r_ent_vld;
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic [AW-1:0]    r_wr_addr;
    logic [DW-1:0]    r_wr_data;
    logic             r_wr_en;

    logic             w_empty;
    logic             w_full;
    logic             w_alu_grant;
    logic             w_mem_fire;
    logic             w_push;
    logic             w_pop;
    logic [DEPTH-1:0] w_ent_vld_nxt;
    logic             w_pending;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CW'(DEPTH));
    assign mem_ready  = !rst && !w_full;
    assign w_mem_fire = mem_valid && mem_ready;

    // Register 0 ALU results are consumed without a grant, so they leave the slot to the queue.
    assign w_alu_grant = alu_valid && (alu_rd != '0) && !alu_stall;
    assign w_pop       = !w_alu_grant && !w_empty;

    // A load to the register the ALU is writing now is older, so it is accepted and dropped.
    assign w_push = w_mem_fire && (mem_rd != '0) && !(w_alu_grant && (mem_rd == alu_rd));

`ifdef WB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] r_starve_cnt;

    assign alu_stall = (r_starve_cnt == SW'(STARVE_LIMIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (w_pop || w_empty) begin
            r_starve_cnt <= '0;
        end else if (w_alu_grant) begin
            r_starve_cnt <= r_starve_cnt + SW'(1);
        end
    end
`else
    assign alu_stall = 1'b0;
`endif

    always_comb begin
        w_ent_vld_nxt = r_ent_vld;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_alu_grant && (r_ent_rd[i] == alu_rd)) begin
                w_ent_vld_nxt[i] = 1'b0;
            end
        end
        if (w_pop) begin
            w_ent_vld_nxt[r_rptr] = 1'b0;
        end
        if (w_push) begin
            w_ent_vld_nxt[r_wptr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ent_vld <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
        end else begin
            r_ent_vld <= w_ent_vld_nxt;
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ent_rd[r_wptr]   <= mem_rd;
            r_ent_data[r_wptr] <= mem_data;
        end
    end

    // A popped entry killed by a younger ALU write still frees its slot but writes nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_wr_en   <= 1'b0;
        end else if (w_alu_grant) begin
            r_wr_addr <= alu_rd;
            r_wr_data <= alu_data;
            r_wr_en   <= 1'b1;
        end else if (w_pop) begin
            r_wr_addr <= r_ent_rd[r_rptr];
            r_wr_data <= r_ent_data[r_rptr];
            r_wr_en   <= r_ent_vld[r_rptr];
        end else begin
            r_wr_en   <= 1'b0;
        end
    end

    always_comb begin
        w_pending = r_wr_en && (r_wr_addr == query_rd);
        for (int i = 0; i < DEPTH; i++) begin
            if (r_ent_vld[i] && (r_ent_rd[i] == query_rd)) begin
                w_pending = 1'b1;
            end
        end
        if (query_rd == '0) begin
            w_pending = 1'b0;
        end
    end

    assign pending    = w_pending;
    assign fifo_count = r_count;
    assign addressw   = r_wr_addr;
    assign writeData  = r_wr_data;
    assign writeEn    = r_wr_en;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: reset, ALU path, queue fill/drain, WAW kill, pending, starvation.
module tb_regfile_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [5:0]  alu_rd;
    logic [63:0] alu_data;
    logic        alu_stall;
    logic        mem_valid;
    logic [5:0]  mem_rd;
    logic [63:0] mem_data;
    logic        mem_ready;
    logic [5:0]  query_rd;
    logic        pending;
    logic [2:0]  fifo_count;
    logic [5:0]  addressw;
    logic [63:0] writeData;
    logic        writeEn;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_writeback dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .alu_stall  (alu_stall),
        .mem_valid  (mem_valid),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .mem_ready  (mem_ready),
        .query_rd   (query_rd),
        .pending    (pending),
        .fifo_count (fifo_count),
        .addressw   (addressw),
        .writeData  (writeData),
        .writeEn    (writeEn)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0; query_rd = '0;
        step(); step();
        n_tests++; if ({writeEn, addressw, writeData, fifo_count} !== '0) begin n_fail++;
            $display("FAIL reset_state: we=%b addr=%0d data=%h cnt=%0d, want all zero", writeEn, addressw, writeData, fifo_count); end
        n_tests++; if ({mem_ready, alu_stall} !== 2'b00) begin n_fail++;
            $display("FAIL reset_ready_stall: ready=%b stall=%b, want 0 0", mem_ready, alu_stall); end
        rst = 1'b0; #1;
        n_tests++; if (mem_ready !== 1'b1) begin n_fail++;
            $display("FAIL ready_after_reset: got %b want 1", mem_ready); end
        alu_valid = 1'b1; alu_rd = 6'd10; alu_data = 64'd1;
        for (int i = 0; i < 3; i++) begin
            mem_valid = 1'b1; mem_rd = 6'(2 + i); mem_data = 64'(i);
            step();
        end
        n_tests++; if (fifo_count !== 3'd3) begin n_fail++;
            $display("FAIL queue3: cnt=%0d want 3", fifo_count); end
        rst = 1'b1; alu_valid = 1'b0; mem_valid = 1'b0;
        step();
        n_tests++; if ({fifo_count, writeEn, mem_ready} !== {3'd0, 1'b0, 1'b0}) begin n_fail++;
            $display("FAIL midqueue_reset: cnt=%0d we=%b ready=%b want 0 0 0", fifo_count, writeEn, mem_ready); end
        rst = 1'b0;
        step();
        n_tests++; if ({fifo_count, writeEn, mem_ready} !== {3'd0, 1'b0, 1'b1}) begin n_fail++;
            $display("FAIL post_reset_idle: cnt=%0d we=%b ready=%b want 0 0 1", fifo_count, writeEn, mem_ready); end
    endtask

    task automatic test_alu_write();
        alu_valid = 1'b1; alu_rd = 6'd1; alu_data = 64'h1234567890ABCDEF; query_rd = 6'd1;
        step();
        n_tests++; if ({writeEn, addressw, writeData} !== {1'b1, 6'd1, 64'h1234567890ABCDEF}) begin n_fail++;
            $display("FAIL alu_write: we=%b addr=%0d data=%h want 1 1 1234567890abcdef", writeEn, addressw, writeData); end
        n_tests++; if (pending !== 1'b1) begin n_fail++;
            $display("FAIL pending_on_write: got %b want 1", pending); end
        alu_rd = 6'd0; alu_data = 64'hDEAD;
        step();
        n_tests++; if (writeEn !== 1'b0) begin n_fail++;
            $display("FAIL alu_rd0: we=%b want 0", writeEn); end
        n_tests++; if (pending !== 1'b0) begin n_fail++;
            $display("FAIL pending_retired: got %b want 0", pending); end
        alu_valid = 1'b0; query_rd = 6'd0;
    endtask

    task automatic test_fifo_full();
        alu_valid = 1'b1; alu_rd = 6'd20; alu_data = 64'd5;
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (mem_ready !== 1'b1) begin n_fail++;
                $display("FAIL ready_before_push%0d: got %b want 1", i, mem_ready); end
            mem_valid = 1'b1; mem_rd = 6'(2 + i); mem_data = 64'(256 + i);
            step();
        end
        n_tests++; if ({fifo_count, mem_ready} !== {3'd4, 1'b0}) begin n_fail++;
            $display("FAIL full: cnt=%0d ready=%b want 4 0", fifo_count, mem_ready); end
        mem_rd = 6'd9; mem_data = 64'h999;
        step();
        n_tests++; if (fifo_count !== 3'd4) begin n_fail++;
            $display("FAIL push_when_full: cnt=%0d want 4", fifo_count); end
        alu_valid = 1'b0; mem_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_tests++; if ({writeEn, addressw, writeData, fifo_count} !== {1'b1, 6'(2 + i), 64'(256 + i), 3'(3 - i)}) begin n_fail++;
                $display("FAIL drain%0d: we=%b addr=%0d data=%h cnt=%0d want 1 %0d %h %0d",
                         i, writeEn, addressw, writeData, fifo_count, 2 + i, 256 + i, 3 - i); end
        end
        step();
        n_tests++; if (writeEn !== 1'b0) begin n_fail++;
            $display("FAIL drain_done: we=%b want 0", writeEn); end
    endtask

    task automatic test_load_latency();
        mem_valid = 1'b1; mem_rd = 6'd6; mem_data = 64'h66;
        step();
        n_tests++; if ({writeEn, fifo_count} !== {1'b0, 3'd1}) begin n_fail++;
            $display("FAIL load_lat1: we=%b cnt=%0d want 0 1", writeEn, fifo_count); end
        mem_rd = 6'd8; mem_data = 64'h88;
        step();
        n_tests++; if ({writeEn, addressw, writeData, fifo_count} !== {1'b1, 6'd6, 64'h66, 3'd1}) begin n_fail++;
            $display("FAIL push_pop: we=%b addr=%0d data=%h cnt=%0d want 1 6 66 1", writeEn, addressw, writeData, fifo_count); end
        mem_valid = 1'b0;
        step();
        n_tests++; if ({writeEn, addressw, writeData, fifo_count} !== {1'b1, 6'd8, 64'h88, 3'd0}) begin n_fail++;
            $display("FAIL second_load: we=%b addr=%0d data=%h cnt=%0d want 1 8 88 0", writeEn, addressw, writeData, fifo_count); end
    endtask

    task automatic test_waw();
        alu_valid = 1'b1; alu_rd = 6'd11; alu_data = 64'h11;
        mem_valid = 1'b1; mem_rd = 6'd7; mem_data = 64'h7777;
        step();
        alu_rd = 6'd7; alu_data = 64'hFEDCBA0987654321; mem_valid = 1'b0; query_rd = 6'd7;
        step();
        n_tests++; if ({writeEn, addressw, writeData, fifo_count} !== {1'b1, 6'd7, 64'hFEDCBA0987654321, 3'd1}) begin n_fail++;
            $display("FAIL waw_alu: we=%b addr=%0d data=%h cnt=%0d want 1 7 fedcba0987654321 1", writeEn, addressw, writeData, fifo_count); end
        alu_valid = 1'b0;
        step();
        n_tests++; if ({writeEn, fifo_count, pending} !== {1'b0, 3'd0, 1'b0}) begin n_fail++;
            $display("FAIL waw_killed_pop: we=%b cnt=%0d pend=%b want 0 0 0", writeEn, fifo_count, pending); end
        alu_valid = 1'b1; alu_rd = 6'd12; alu_data = 64'h12;
        mem_valid = 1'b1; mem_rd = 6'd12; mem_data = 64'hBAD;
        step();
        n_tests++; if ({writeEn, addressw, writeData, fifo_count} !== {1'b1, 6'd12, 64'h12, 3'd0}) begin n_fail++;
            $display("FAIL waw_same_cycle: we=%b addr=%0d data=%h cnt=%0d want 1 12 12 0", writeEn, addressw, writeData, fifo_count); end
        mem_rd = 6'd0;
        step();
        n_tests++; if (fifo_count !== 3'd0) begin n_fail++;
            $display("FAIL load_rd0: cnt=%0d want 0", fifo_count); end
        alu_valid = 1'b0; mem_valid = 1'b0; query_rd = 6'd0;
        step();
    endtask

    task automatic test_pending();
        alu_valid = 1'b1; alu_rd = 6'd13; alu_data = 64'h13;
        mem_valid = 1'b1; mem_rd = 6'd3; mem_data = 64'h33;
        query_rd = 6'd3;
        step();
        n_tests++; if ({pending, fifo_count} !== {1'b1, 3'd1}) begin n_fail++;
            $display("FAIL pending_queued: pend=%b cnt=%0d want 1 1", pending, fifo_count); end
        query_rd = 6'd0; #1;
        n_tests++; if (pending !== 1'b0) begin n_fail++;
            $display("FAIL pending_r0: got %b want 0", pending); end
        query_rd = 6'd3; alu_valid = 1'b0; mem_valid = 1'b0;
        step();
        n_tests++; if ({pending, writeEn, addressw} !== {1'b1, 1'b1, 6'd3}) begin n_fail++;
            $display("FAIL pending_writing: pend=%b we=%b addr=%0d want 1 1 3", pending, writeEn, addressw); end
        step();
        n_tests++; if (pending !== 1'b0) begin n_fail++;
            $display("FAIL pending_done: got %b want 0", pending); end
        query_rd = 6'd0;
    endtask

    task automatic test_starve();
        alu_valid = 1'b1; alu_rd = 6'd14; alu_data = 64'h500;
        mem_valid = 1'b1; mem_rd = 6'd15; mem_data = 64'hABC;
        step();
        mem_valid = 1'b0;
`ifdef WB_STARVE_GUARD_EN
        for (int i = 1; i <= 8; i++) begin
            alu_data = 64'(32'h500 + i);
            step();
            n_tests++; if ({writeEn, addressw, writeData, alu_stall} !== {1'b1, 6'd14, 64'(32'h500 + i), (i == 8)}) begin n_fail++;
                $display("FAIL starve_cycle%0d: we=%b addr=%0d data=%h stall=%b", i, writeEn, addressw, writeData, alu_stall); end
        end
        alu_data = 64'h5FF;
        step();
        n_tests++; if ({writeEn, addressw, writeData, fifo_count, alu_stall} !== {1'b1, 6'd15, 64'hABC, 3'd0, 1'b0}) begin n_fail++;
            $display("FAIL starve_drain: we=%b addr=%0d data=%h cnt=%0d stall=%b want 1 15 abc 0 0",
                     writeEn, addressw, writeData, fifo_count, alu_stall); end
        step();
        n_tests++; if ({writeEn, addressw, writeData} !== {1'b1, 6'd14, 64'h5FF}) begin n_fail++;
            $display("FAIL starve_represent: we=%b addr=%0d data=%h want 1 14 5ff", writeEn, addressw, writeData); end
        alu_valid = 1'b0;
        step();
`else
        for (int i = 1; i <= 12; i++) begin
            alu_data = 64'(32'h500 + i);
            step();
            n_tests++; if ({writeEn, addressw, writeData, fifo_count, alu_stall} !== {1'b1, 6'd14, 64'(32'h500 + i), 3'd1, 1'b0}) begin n_fail++;
                $display("FAIL starve_cycle%0d: we=%b addr=%0d data=%h cnt=%0d stall=%b", i, writeEn, addressw, writeData, fifo_count, alu_stall); end
        end
        alu_valid = 1'b0;
        step();
        n_tests++; if ({writeEn, addressw, writeData, fifo_count} !== {1'b1, 6'd15, 64'hABC, 3'd0}) begin n_fail++;
            $display("FAIL starve_release: we=%b addr=%0d data=%h cnt=%0d want 1 15 abc 0", writeEn, addressw, writeData, fifo_count); end
`endif
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_fifo_full();
        test_load_latency();
        test_waw();
        test_pending();
        test_starve();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
